countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Consumes the single-cycle tick strobe from the design's low-rate tick generator.
- Implements the TypeRacer round timer: loads a second count, counts down in BCD, supports pause and abort, and signals expiry.
- Its outputs drive the seven-segment display and the game-control FSM.

Parameters:
- TICKS_PER_SEC, 10, number of tick strobes per displayed second; legal range 1..255.
- MAX_SEC, 99, ceiling applied to the loaded second count; must be ≤ 99.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  one-cycle strobe from the tick generator, synchronous to clk.
- start  input  1  one-cycle request: load load_sec and begin counting.
- pause  input  1  level; while high, counting is frozen.
- abort  input  1  one-cycle request: return to IDLE and clear.
- load_sec  input  7  initial seconds, unsigned binary 0..127.
- sec_tens  output  4  BCD tens digit of remaining seconds.
- sec_ones  output  4  BCD ones digit of remaining seconds.
- running  output  1  high in RUN state.
- paused  output  1  high in PAUSED state.
- done  output  1  level, high in DONE state.
- expired  output  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset, asynchronous, while rst_n is low:
  - state = IDLE, sub_cnt = 0.
  - sec_tens = sec_ones = 0.
  - running = paused = done = expired = 0.
- Reset mid-operation behaves identically; no pending pulse survives reset.
- All outputs are registered. running, paused and done are decoded from the state register, so they update in the same cycle as the state.
- States: IDLE, RUN, PAUSED, DONE.
- Per-cycle event priority: abort > start > pause > tick.
- abort (any state): next state IDLE; digits = 0; sub_cnt = 0; expired = 0.
- start (any state, including RUN/PAUSED, which restarts the count):
  - eff = min(load_sec, MAX_SEC).
  - sec_tens = eff/10, sec_ones = eff%10, sub_cnt = 0.
  - If eff == 0: next state DONE and expired = 1 next cycle.
  - Otherwise: next state RUN.
  - A tick in the same cycle as start is discarded.
- RUN:
  - If pause is high: go to PAUSED. Any tick in that cycle is discarded.
  - Else if tick:
    - If sub_cnt == TICKS_PER_SEC-1: sub_cnt = 0 and decrement BCD seconds:
      - ones != 0 → ones−1.
      - ones == 0 → ones = 9, tens−1.
    - If the decremented value is 00: next state DONE, expired = 1 for exactly one cycle.
    - Otherwise: sub_cnt + 1.
- PAUSED:
  - Ticks are ignored; sub_cnt and digits are held.
  - pause low → RUN on the next cycle. The partial sub-second count is preserved.
- DONE: digits held at 00; ticks ignored; done = 1. Leave only via start or abort.
- IDLE: ticks and pause are ignored; digits hold 00.
- Latency: expired asserts on the clock edge that samples the final tick, i.e. 1 cycle after the tick is presented; digits read 00 in the same cycle.
- Widths: sub_cnt is 8 bits. The binary→BCD conversion of eff is combinational (eff ≤ 99). No wrap below 00 is possible.
- Elapsed seconds from start to expired = eff × TICKS_PER_SEC ticks.

Test Plan:
- Reset: rst_n low mid-RUN with digits at 37 → all outputs 0 immediately (asynchronously), state IDLE; after release, ticks leave digits at 00.
- Basic countdown (TICKS_PER_SEC = 10): start with load_sec = 3 → digits 03, running = 1.
  - After 10 ticks → 02; after 30 ticks → 00.
  - done = 1 and a single-cycle expired on the cycle after the 30th tick.
- BCD borrow and clamp:
  - load_sec = 10, 10 ticks → digits 09 (tens 0, ones 9).
  - load_sec = 120 → digits 99.
- Pause: load 5, 7 ticks, pause high, 20 ticks, pause low → digits still 05.
  - 3 further ticks → 04 (sub-count preserved).
  - A tick coincident with pause assertion is not counted.
- Simultaneous events:
  - start + tick in the same cycle while in RUN at 02 → reload to load_sec, tick ignored.
  - abort + start in the same cycle → IDLE, digits 00.
- Zero load: start with load_sec = 0 → DONE next cycle, expired pulses once, running never asserts.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: round timer that loads a second count, counts it down in
// BCD on tick strobes, supports pause/abort and reports expiry.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   tick                one-cycle strobe from the low-rate tick generator
//   start               one-cycle request: load load_sec and begin counting
//   pause               level; freezes counting while high
//   abort               one-cycle request: return to IDLE and clear
//   load_sec[6:0]       initial seconds, clamped to MAX_SEC
//   sec_tens, sec_ones  BCD digits of remaining seconds
//   running/paused/done state flags (done is a level in DONE)
//   expired             one-cycle pulse on entry to DONE
module countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 10,
  parameter int unsigned MAX_SEC       = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [6:0] load_sec,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       paused,
  output logic       done,
  output logic       expired
);

  localparam int unsigned SUB_W = 8;
  localparam int unsigned SEC_W = 7;
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0] MAX_CLAMP = SEC_W'(MAX_SEC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [3:0]       tens_d, ones_d;
  logic             expired_d;

  // Clamped load value and its BCD split (eff never exceeds 99)
  logic [SEC_W-1:0] eff_c;
  logic [3:0]       load_tens_c, load_ones_c;
  assign eff_c       = (load_sec > MAX_CLAMP) ? MAX_CLAMP : load_sec;
  assign load_tens_c = 4'(eff_c / SEC_W'(10));
  assign load_ones_c = 4'(eff_c % SEC_W'(10));

  // One-second BCD decrement with borrow from the tens digit
  logic [3:0] tens_dec_c, ones_dec_c;
  logic       last_sec_c;
  assign ones_dec_c = (sec_ones != 4'd0) ? (sec_ones - 4'd1) : 4'd9;
  assign tens_dec_c = (sec_ones != 4'd0) ? sec_tens : (sec_tens - 4'd1);
  assign last_sec_c = (sec_tens == 4'd0) && (sec_ones == 4'd1);

  // Next-state logic; event priority abort > start > pause > tick
  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    tens_d    = sec_tens;
    ones_d    = sec_ones;
    expired_d = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      sub_d   = '0;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
    end else if (start) begin
      sub_d  = '0;
      tens_d = load_tens_c;
      ones_d = load_ones_c;
      if (eff_c == '0) begin
        state_d   = ST_DONE;
        expired_d = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            if (sub_q == SUB_LAST) begin
              sub_d  = '0;
              tens_d = tens_dec_c;
              ones_d = ones_dec_c;
              if (last_sec_c) begin
                state_d   = ST_DONE;
                expired_d = 1'b1;
              end
            end else begin
              sub_d = sub_q + SUB_W'(1);
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) state_d = ST_RUN;
        end
        ST_DONE: ;
        ST_IDLE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers; flags follow the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sub_q    <= '0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      running  <= 1'b0;
      paused   <= 1'b0;
      done     <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sub_q    <= sub_d;
      sec_tens <= tens_d;
      sec_ones <= ones_d;
      running  <= (state_d == ST_RUN);
      paused   <= (state_d == ST_PAUSED);
      done     <= (state_d == ST_DONE);
      expired  <= expired_d;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer: directed scenarios plus randomized traffic
// compared against an integer-seconds reference model.
module tb_countdown_timer;

  localparam int unsigned TPS  = 10;
  localparam int unsigned MAXS = 99;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [6:0] load_sec = 7'd0;
  logic [3:0] sec_tens, sec_ones;
  logic       running, paused, done, expired;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle, 1 run, 2 paused, 3 done; seconds as an integer
  int m_mode = 0;
  int m_sec  = 0;
  int m_sub  = 0;
  bit m_exp  = 1'b0;

  countdown_timer #(.TICKS_PER_SEC(TPS), .MAX_SEC(MAXS)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .pause(pause),
    .abort(abort), .load_sec(load_sec), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .paused(paused), .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_digits();
    return {4'(m_sec / 10), 4'(m_sec % 10)};
  endfunction

  function automatic logic [3:0] exp_flags();
    return {m_mode == 1, m_mode == 2, m_mode == 3, m_exp};
  endfunction

  // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge
  task automatic step(input bit t, input bit s, input bit p, input bit a, input int ls);
    int eff;
    tick = t; start = s; pause = p; abort = a; load_sec = 7'(ls);
    @(posedge clk);
    m_exp = 1'b0;
    if (a) begin
      m_mode = 0; m_sec = 0; m_sub = 0;
    end else if (s) begin
      eff = (ls > MAXS) ? MAXS : ls;
      m_sec = eff; m_sub = 0;
      if (eff == 0) begin m_mode = 3; m_exp = 1'b1; end
      else m_mode = 1;
    end else if (m_mode == 1) begin
      if (p) m_mode = 2;
      else if (t) begin
        if (m_sub == TPS - 1) begin
          m_sub = 0;
          m_sec = m_sec - 1;
          if (m_sec == 0) begin m_mode = 3; m_exp = 1'b1; end
        end else m_sub = m_sub + 1;
      end
    end else if (m_mode == 2) begin
      if (!p) m_mode = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0);
    n_checks++;
    if ({sec_tens, sec_ones, running, paused, done, expired} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_init: got %h required 000", {sec_tens, sec_ones, running, paused, done, expired});
    end
    step(0, 1, 0, 0, 37);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    n_checks++;
    if ({sec_tens, sec_ones} !== 8'h37 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prerun: digits %h running %b required 37/1", {sec_tens, sec_ones}, running);
    end
    #2 rst_n = 1'b0;
    #1;
    m_mode = 0; m_sec = 0; m_sub = 0; m_exp = 1'b0;
    n_checks++;
    if ({sec_tens, sec_ones, running, paused, done, expired} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_async: got %h required 000", {sec_tens, sec_ones, running, paused, done, expired});
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step(1, 0, (i % 3) == 0, 0, 0);
    n_checks++;
    if ({sec_tens, sec_ones, running, paused, done, expired} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_idle_ticks: got %h required 000", {sec_tens, sec_ones, running, paused, done, expired});
    end
  endtask

  task automatic test_basic();
    step(0, 1, 0, 0, 3);
    n_checks++;
    if ({sec_tens, sec_ones} !== 8'h03 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_load: digits %h running %b required 03/1", {sec_tens, sec_ones}, running);
    end
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
    n_checks++;
    if ({sec_tens, sec_ones} !== 8'h02) begin
      n_fail++;
      $display("FAIL basic_10ticks: digits %h required 02", {sec_tens, sec_ones});
    end
    for (int i = 0; i < 19; i++) step(1, 0, 0, 0, 0);
    n_checks++;
    if ({sec_tens, sec_ones} !== 8'h01 || done !== 1'b0 || expired !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_29ticks: digits %h done %b expired %b required 01/0/0", {sec_tens, sec_ones}, done, expired);
    end
    step(1, 0, 0, 0, 0);
    n_checks++;
    if ({sec_tens, sec_ones} !== 8'h00 || done !== 1'b1 || expired !== 1'b1 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_expire: digits %h done %b expired %b running %b required 00/1/1/0",
               {sec_tens, sec_ones}, done, expired, running);
    end
    step(1, 0, 0, 0, 0);
    n_checks++;
    if ({sec_tens, sec_ones} !== 8'h00 || done !== 1'b1 || expired !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_expire_once: digits %h done %b expired %b required 00/1/0", {sec_tens, sec_ones}, done, expired);
    end
  endtask

  task automatic test_bcd_clamp();
    step(0, 1, 0, 0, 10);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
    n_checks++;
    if ({sec_tens, sec_ones} !== 8'h09) begin
      n_fail++;
      $display("FAIL bcd_borrow: digits %h required 09", {sec_tens, sec_ones});
    end
    step(0, 1, 0, 0, 120);
    n_checks++;
    if ({sec_tens, sec_ones} !== 8'h99 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_120: digits %h running %b required 99/1", {sec_tens, sec_ones}, running);
    end
  endtask

  task automatic test_pause();
    step(0, 1, 0, 0, 5);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    n_checks++;
    if (paused !== 1'b1 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_enter: paused %b running %b required 1/0", paused, running);
    end
    for (int i = 0; i < 20; i++) step(1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    n_checks++;
    if ({sec_tens, sec_ones} !== 8'h05 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_hold: digits %h running %b required 05/1", {sec_tens, sec_ones}, running);
    end
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    n_checks++;
    if ({sec_tens, sec_ones} !== 8'h05) begin
      n_fail++;
      $display("FAIL pause_coincident_tick: digits %h required 05", {sec_tens, sec_ones});
    end
    step(1, 0, 0, 0, 0);
    n_checks++;
    if ({sec_tens, sec_ones} !== 8'h04) begin
      n_fail++;
      $display("FAIL pause_subcount: digits %h required 04", {sec_tens, sec_ones});
    end
  endtask

  task automatic test_simultaneous();
    step(0, 1, 0, 0, 3);
    for (int i = 0; i < 15; i++) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 7);
    n_checks++;
    if ({sec_tens, sec_ones} !== 8'h07 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL start_tick_reload: digits %h running %b required 07/1", {sec_tens, sec_ones}, running);
    end
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0);
    n_checks++;
    if ({sec_tens, sec_ones} !== 8'h07) begin
      n_fail++;
      $display("FAIL start_tick_discard: digits %h required 07", {sec_tens, sec_ones});
    end
    step(1, 0, 0, 0, 0);
    n_checks++;
    if ({sec_tens, sec_ones} !== 8'h06) begin
      n_fail++;
      $display("FAIL start_subreset: digits %h required 06", {sec_tens, sec_ones});
    end
    step(1, 1, 1, 1, 50);
    n_checks++;
    if ({sec_tens, sec_ones, running, paused, done, expired} !== 12'h000) begin
      n_fail++;
      $display("FAIL abort_start: got %h required 000", {sec_tens, sec_ones, running, paused, done, expired});
    end
  endtask

  task automatic test_zero_load();
    bit saw_run = 1'b0;
    int pulses = 0;
    step(0, 1, 0, 0, 0);
    saw_run |= running; pulses += int'(expired);
    n_checks++;
    if (done !== 1'b1 || expired !== 1'b1 || {sec_tens, sec_ones} !== 8'h00) begin
      n_fail++;
      $display("FAIL zero_load: done %b expired %b digits %h required 1/1/00", done, expired, {sec_tens, sec_ones});
    end
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 0, 0, 0);
      saw_run |= running; pulses += int'(expired);
    end
    n_checks++;
    if (saw_run !== 1'b0 || pulses != 1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_load_after: saw_run %b pulses %0d done %b required 0/1/1", saw_run, pulses, done);
    end
  endtask

  task automatic test_random();
    bit p_lvl = 1'b0;
    bit t, s, a;
    int ls;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) p_lvl = ~p_lvl;
      t  = ($urandom_range(0, 1) == 1);
      s  = ($urandom_range(0, 149) == 0);
      a  = ($urandom_range(0, 599) == 0);
      ls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 4));
      step(t, s, p_lvl, a, ls);
      n_checks++;
      if ({sec_tens, sec_ones} !== exp_digits()) begin
        n_fail++;
        $display("FAIL rand_digits cyc %0d: got %h required %h", i, {sec_tens, sec_ones}, exp_digits());
      end
      n_checks++;
      if ({running, paused, done, expired} !== exp_flags()) begin
        n_fail++;
        $display("FAIL rand_flags cyc %0d: got %b required %b", i, {running, paused, done, expired}, exp_flags());
      end
    end
  endtask

  initial begin
    #12 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_bcd_clamp();
    test_pause();
    test_simultaneous();
    test_zero_load();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
